// File: rtl/apb_pkg.sv
// Shared types and constants for the N-slave APB master.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam logic RSP_OKAY = 1'b0;
    localparam logic RSP_ERR  = 1'b1;

endpackage

// File: rtl/apb_sel_decode.sv
// Slave index decode: one-hot select vector plus out-of-range flag.
module apb_sel_decode #(
    parameter int NUM_SLV  = 4,
    parameter int SEL_BITS = 2
) (
    input  logic [SEL_BITS-1:0] idx,
    output logic [NUM_SLV-1:0]  onehot,
    output logic                oor
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            onehot[i] = (32'(idx) == 32'(i));
        end
        oor = (32'(idx) >= 32'(NUM_SLV));
    end

endmodule

// File: rtl/apb_master_nsel.sv
// APB master fanning one request port out to NUM_SLV slaves.
// Optional ACCESS-phase timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_nsel
    import apb_pkg::*;
#(
    parameter int  ADDR_WIDTH  = 8,
    parameter int  DATA_WIDTH  = 32,
    parameter int  NUM_SLV     = 4,
    parameter int  TIMEOUT_CYC = 16,
    localparam int SEL_BITS    = $clog2(NUM_SLV),
    localparam int STRB_W      = DATA_WIDTH / 8
) (
    input  logic                           PCLK,
    input  logic                           PRESET,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_write,
    input  logic [SEL_BITS+ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]          req_wdata,
    input  logic [STRB_W-1:0]              req_strb,
    output logic                           rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic                           rsp_err,
    output logic [NUM_SLV-1:0]             PSEL,
    output logic                           PENABLE,
    output logic                           PWRITE,
    output logic [ADDR_WIDTH-1:0]          PADDR,
    output logic [DATA_WIDTH-1:0]          PWDATA,
    output logic [STRB_W-1:0]              PSTRB,
    input  logic [NUM_SLV-1:0]             PREADY,
    input  logic [NUM_SLV-1:0]             PSLVERR,
    input  logic [NUM_SLV*DATA_WIDTH-1:0]  PRDATA
);

    if (NUM_SLV < 2 || NUM_SLV > 16 || TIMEOUT_CYC < 1 || (DATA_WIDTH % 8) != 0) begin : g_cfg_check
        $error("apb_master_nsel: unsupported parameter set");
    end

    apb_state_e           state, state_nxt;
    logic [NUM_SLV-1:0]   sel_q;
    logic [NUM_SLV-1:0]   dec_onehot;
    logic                 dec_oor;
    logic                 pready_sel, pslverr_sel;
    logic [DATA_WIDTH-1:0] prdata_sel;
    logic                 accept, complete, timeout;

    apb_sel_decode #(
        .NUM_SLV  (NUM_SLV),
        .SEL_BITS (SEL_BITS)
    ) u_dec (
        .idx    (req_addr[ADDR_WIDTH +: SEL_BITS]),
        .onehot (dec_onehot),
        .oor    (dec_oor)
    );

    // Slave return path muxed by the captured one-hot select only.
    always_comb begin
        pready_sel  = |(PREADY & sel_q);
        pslverr_sel = |(PSLVERR & sel_q);
        prdata_sel  = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sel_q[i]) prdata_sel = prdata_sel | PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign complete = (state == ST_ACCESS) && pready_sel;
    assign accept   = req_valid && req_ready;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] to_cnt;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)                  to_cnt <= '0;
        else if (state != ST_ACCESS) to_cnt <= '0;
        else if (!pready_sel)        to_cnt <= to_cnt + CNT_W'(1);
    end

    assign timeout = (state == ST_ACCESS) && !pready_sel && (to_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept && !dec_oor) state_nxt = ST_SETUP;
            ST_SETUP:  state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (complete)     state_nxt = accept ? ST_SETUP : ST_IDLE;
                else if (timeout) state_nxt = ST_IDLE;
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // An out-of-range request is held off during a completing ACCESS so its
    // error response cannot collide with the completion response.
    always_comb begin
        PSEL      = (state == ST_SETUP || state == ST_ACCESS) ? sel_q : '0;
        PENABLE   = (state == ST_ACCESS);
        req_ready = 1'b0;
        if (!PRESET) begin
            case (state)
                ST_IDLE:   req_ready = 1'b1;
                ST_ACCESS: req_ready = pready_sel && !(req_valid && dec_oor);
                default:   req_ready = 1'b0;
            endcase
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            sel_q     <= '0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                PWRITE <= req_write;
                PADDR  <= req_addr[ADDR_WIDTH-1:0];
                PWDATA <= req_wdata;
                PSTRB  <= req_strb;
                if (!dec_oor) sel_q <= dec_onehot;
            end
            rsp_valid <= 1'b0;
            if (accept && dec_oor) begin
                rsp_valid <= 1'b1;
                rsp_err   <= RSP_ERR;
                rsp_rdata <= '0;
            end else if (complete) begin
                rsp_valid <= 1'b1;
                rsp_err   <= pslverr_sel ? RSP_ERR : RSP_OKAY;
                rsp_rdata <= PWRITE ? '0 : prdata_sel;
            end else if (timeout) begin
                rsp_valid <= 1'b1;
                rsp_err   <= RSP_ERR;
                rsp_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_nsel.sv
// Bench for apb_master_nsel with five slaves (indices 5..7 out of range).
module tb_apb_master_nsel;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NS = 5;
    localparam int SB = $clog2(NS);
    localparam int SW = DW / 8;

    logic              PCLK = 1'b0;
    logic              PRESET = 1'b0;
    logic              req_valid, req_ready, req_write;
    logic [SB+AW-1:0]  req_addr;
    logic [DW-1:0]     req_wdata;
    logic [SW-1:0]     req_strb;
    logic              rsp_valid, rsp_err;
    logic [DW-1:0]     rsp_rdata;
    logic [NS-1:0]     PSEL;
    logic              PENABLE, PWRITE;
    logic [AW-1:0]     PADDR;
    logic [DW-1:0]     PWDATA;
    logic [SW-1:0]     PSTRB;
    logic [NS-1:0]     PREADY, PSLVERR;
    logic [NS*DW-1:0]  PRDATA;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 PCLK = ~PCLK;

    apb_master_nsel #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_SLV    (NS),
        .TIMEOUT_CYC(16)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .PRDATA    (PRDATA)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Selected slave gets the given response; every other slave gets noise.
    task automatic set_slaves(input int sel, input logic rdy, input logic err, input logic [DW-1:0] rd);
        for (int i = 0; i < NS; i++) begin
            if (i == sel) begin
                PREADY[i] = rdy;
                PSLVERR[i] = err;
                PRDATA[i*DW +: DW] = rd;
            end else begin
                PREADY[i] = 1'($urandom);
                PSLVERR[i] = 1'($urandom);
                PRDATA[i*DW +: DW] = $urandom;
            end
        end
    endtask

    function automatic logic [NS-1:0] onehot(input int idx);
        logic [NS-1:0] v;
        v = '0;
        if (idx < NS) v[idx] = 1'b1;
        return v;
    endfunction

    // One isolated transfer, expectations derived from the request and slave response.
    task automatic xfer(input logic w, input logic [SB+AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [SW-1:0] st, input int waits, input logic serr, input logic [DW-1:0] rd);
        int idx;
        logic [DW-1:0] exp_rd;
        idx = int'(addr[AW +: SB]);
        exp_rd = w ? '0 : rd;
        req_valid = 1'b1; req_write = w; req_addr = addr; req_wdata = wd; req_strb = st;
        set_slaves(-1, 1'b0, 1'b0, '0);
        #1 check("idle_ready", req_ready, 1);
        tick();
        req_valid = 1'b0; req_write = 1'($urandom); req_addr = (SB+AW)'($urandom);
        req_wdata = $urandom; req_strb = SW'($urandom);
        if (idx >= NS) begin
            check("oor_psel", PSEL, 0);
            check("oor_penable", PENABLE, 0);
            check("oor_rsp_valid", rsp_valid, 1);
            check("oor_rsp_err", rsp_err, 1);
            check("oor_rsp_rdata", rsp_rdata, 0);
            tick();
            check("oor_rsp_pulse", rsp_valid, 0);
            check("oor_psel_after", PSEL, 0);
            return;
        end
        check("setup_psel", PSEL, onehot(idx));
        check("setup_penable", PENABLE, 0);
        check("setup_pwrite", PWRITE, w);
        check("setup_paddr", PADDR, addr[AW-1:0]);
        check("setup_pwdata", PWDATA, wd);
        check("setup_pstrb", PSTRB, st);
        check("setup_rsp", rsp_valid, 0);
        set_slaves(idx, 1'($urandom), 1'($urandom), $urandom);
        #1 check("setup_ready", req_ready, 0);
        for (int k = 0; k <= waits; k++) begin
            tick();
            set_slaves(idx, (k == waits), serr, rd);
            #1;
            check("acc_psel", PSEL, onehot(idx));
            check("acc_penable", PENABLE, 1);
            check("acc_paddr", PADDR, addr[AW-1:0]);
            check("acc_pwdata", PWDATA, wd);
            check("acc_ready", req_ready, (k == waits));
            check("acc_rsp", rsp_valid, 0);
        end
        tick();
        check("done_rsp_valid", rsp_valid, 1);
        check("done_rsp_err", rsp_err, serr);
        check("done_rsp_rdata", rsp_rdata, exp_rd);
        check("done_psel", PSEL, 0);
        check("done_penable", PENABLE, 0);
        set_slaves(-1, 1'b0, 1'b0, '0);
        tick();
        check("rsp_pulse", rsp_valid, 0);
        check("rsp_hold_rdata", rsp_rdata, exp_rd);
        check("rsp_hold_err", rsp_err, serr);
    endtask

    // Put a read to slave sel into ACCESS with PREADY held low.
    task automatic start_stuck(input int sel, input logic [AW-1:0] pa);
        req_valid = 1'b1; req_write = 1'b0; req_addr = {SB'(sel), pa};
        req_wdata = '0; req_strb = '0;
        set_slaves(sel, 1'b0, 1'b0, $urandom);
        tick();
        req_valid = 1'b0;
        set_slaves(sel, 1'b0, 1'b0, $urandom);
        tick();
        check("stuck_enter_access", PENABLE, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] rd_a, rd_b;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_strb = '0;
        PREADY = '0; PSLVERR = '0; PRDATA = '0;

        #1 PRESET = 1'b1;
        #2;
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_paddr", PADDR, 0);
        repeat (2) @(posedge PCLK);
        @(negedge PCLK) PRESET = 1'b0;
        #1 check("rst_release_ready", req_ready, 1);
        tick();

        // Directed: zero-wait write to slave 1, waited read from slave 3.
        xfer(1'b1, 11'h124, 32'hDEADBEEF, 4'hF, 0, 1'b0, $urandom);
        xfer(1'b0, 11'h310, 32'h0, 4'h0, 3, 1'b0, 32'h12345678);
        // Out-of-range indices (boundary = NUM_SLV) and slave error.
        xfer(1'b0, 11'h500, 32'h0, 4'h0, 0, 1'b0, $urandom);
        xfer(1'b1, 11'h7FF, 32'h55AA55AA, 4'h3, 0, 1'b0, $urandom);
        xfer(1'b0, 11'h240, 32'h0, 4'h0, 1, 1'b1, 32'hCAFEF00D);

        // Back-to-back reads: slave 0 then slave 2 with req_valid held.
        rd_a = $urandom; rd_b = $urandom;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 11'h008; req_wdata = '0; req_strb = '0;
        set_slaves(-1, 1'b0, 1'b0, '0);
        #1 check("b2b_ready_a", req_ready, 1);
        tick();
        req_addr = 11'h20C;
        check("b2b_setup_psel", PSEL, 5'b00001);
        set_slaves(0, 1'b1, 1'b0, rd_a);
        #1 check("b2b_setup_ready", req_ready, 0);
        tick();
        set_slaves(0, 1'b1, 1'b0, rd_a);
        #1;
        check("b2b_access_ready", req_ready, 1);
        check("b2b_access_penable", PENABLE, 1);
        tick();
        req_valid = 1'b0;
        check("b2b_rsp_a", rsp_valid, 1);
        check("b2b_rdata_a", rsp_rdata, rd_a);
        check("b2b_setup_b_psel", PSEL, 5'b00100);
        check("b2b_setup_b_penable", PENABLE, 0);
        check("b2b_setup_b_paddr", PADDR, 8'h0C);
        set_slaves(2, 1'b1, 1'b0, rd_b);
        tick();
        set_slaves(2, 1'b1, 1'b0, rd_b);
        check("b2b_access_b_rsp", rsp_valid, 0);
        check("b2b_access_b_penable", PENABLE, 1);
        tick();
        check("b2b_rsp_b", rsp_valid, 1);
        check("b2b_rdata_b", rsp_rdata, rd_b);
        check("b2b_done_psel", PSEL, 0);
        tick();
        check("b2b_rsp_pulse", rsp_valid, 0);

        // Randomized transfers, including out-of-range indices.
        for (int n = 0; n < 40; n++) begin
            xfer(1'($urandom), {SB'($urandom_range(0, 7)), AW'($urandom)}, $urandom, SW'($urandom),
                 $urandom_range(0, 3), 1'($urandom), $urandom);
        end

        // PREADY stuck low on slave 4.
        start_stuck(4, 8'h44);
`ifdef APB_MASTER_TIMEOUT_EN
        for (int k = 1; k < 16; k++) begin
            tick();
            set_slaves(4, 1'b0, 1'b0, $urandom);
            check("to_access", PENABLE, 1);
            check("to_no_rsp", rsp_valid, 0);
        end
        tick();
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rsp_err", rsp_err, 1);
        check("to_rsp_rdata", rsp_rdata, 0);
        check("to_psel", PSEL, 0);
        check("to_penable", PENABLE, 0);
        tick();
`else
        for (int k = 0; k < 20; k++) begin
            tick();
            set_slaves(4, 1'b0, 1'b0, $urandom);
            check("stuck_access", PENABLE, 1);
            check("stuck_psel", PSEL, 5'b10000);
            check("stuck_no_rsp", rsp_valid, 0);
        end
`endif

        // Reset in the middle of ACCESS aborts without a response.
        start_stuck(2, 8'h9C);
        tick();
        set_slaves(2, 1'b1, 1'b0, $urandom);
        #2 PRESET = 1'b1;
        #1;
        check("abort_psel", PSEL, 0);
        check("abort_penable", PENABLE, 0);
        check("abort_paddr", PADDR, 0);
        check("abort_ready", req_ready, 0);
        check("abort_rsp", rsp_valid, 0);
        @(negedge PCLK) PRESET = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("abort_no_rsp", rsp_valid, 0);
            check("abort_idle_ready", req_ready, 1);
        end
        xfer(1'b0, 11'h2A0, 32'h0, 4'h0, 2, 1'b0, 32'h0BADBEEF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/apb_master_nsel.md
APB_MASTER_NSEL -- requirements
Module: apb_master_nsel

Interface
REQ-001 SHALL have param ADDR_WIDTH, 8, slave-local address bits.
REQ-002 SHALL have param DATA_WIDTH, 32, data bits (multiple of 8).
REQ-003 SHALL have param NUM_SLV, 4, slave count (2..16); SEL_BITS = clog2(NUM_SLV).
REQ-004 SHALL have param TIMEOUT_CYC, 16, max ACCESS cycles (used only with timeout macro).
REQ-005 SHALL use one clock and an asynchronous, active-high reset:
- PCLK  in  1  clock, all logic rising-edge
- PRESET  in  1  reset
REQ-006 SHALL have request ports:
- req_valid  in  1  request offered
- req_ready  out  1  request accepted this edge
- req_write  in  1  1=write
- req_addr  in  SEL_BITS+ADDR_WIDTH  slave index in upper SEL_BITS
- req_wdata  in  DATA_WIDTH  write data
- req_strb  in  DATA_WIDTH/8  byte strobes
REQ-007 SHALL have response ports:
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_WIDTH  read data
- rsp_err  out  1  slave/decode/timeout error
REQ-008 SHALL have APB ports:
- PSEL  out  NUM_SLV  one-hot select
- PENABLE  out  1  access phase
- PWRITE, PADDR[ADDR_WIDTH], PWDATA, PSTRB  out  registered transfer fields
- PREADY, PSLVERR  in  NUM_SLV  per-slave
- PRDATA  in  NUM_SLV*DATA_WIDTH  packed, slave i at [i*DATA_WIDTH +: DATA_WIDTH]

Function
REQ-009 SHALL implement FSM IDLE, SETUP, ACCESS; IDLE->SETUP on accepted request; SETUP->ACCESS unconditionally; ACCESS->SETUP if selected PREADY=1 and new request accepted, ACCESS->IDLE if PREADY=1 and none, else stay.
REQ-010 SHALL assert req_ready in IDLE, and in ACCESS when selected PREADY=1; never in SETUP.
REQ-011 SHALL register PWRITE/PADDR/PWDATA/PSTRB/select index on acceptance; all held stable through SETUP and ACCESS, held at last value in IDLE.
REQ-012 SHALL drive PSEL one-hot for captured index in SETUP/ACCESS, zero in IDLE; PENABLE=1 only in ACCESS.
REQ-013 SHALL mux PREADY/PSLVERR/PRDATA from the captured index only; other slaves ignored.
REQ-014 SHALL, on index >= NUM_SLV, not enter SETUP, assert no PSEL, and pulse rsp_valid with rsp_err=1, rsp_rdata=0 the cycle after acceptance.
REQ-015 SHALL, on completion (ACCESS, PREADY=1), pulse rsp_valid next cycle with rsp_err=PSLVERR, rsp_rdata=PRDATA for reads, 0 for writes.
REQ-016 SHALL give zero-wait latency: accept edge N, SETUP N..N+1, ACCESS N+1..N+2, rsp_valid high N+2..N+3.
REQ-017 SHALL keep rsp_rdata/rsp_err stable until next rsp_valid.

Reset
REQ-018 SHALL on PRESET asynchronously force IDLE and all outputs zero (req_ready becomes 1 after release).
REQ-019 SHALL, on reset during SETUP/ACCESS, abort silently: no rsp_valid for that transfer.

Configuration
REQ-020 SHALL, with APB_MASTER_TIMEOUT_EN defined, count ACCESS cycles; at TIMEOUT_CYC with PREADY still 0 go IDLE, pulse rsp_valid, rsp_err=1, rsp_rdata=0; counter clears on entering SETUP.
REQ-021 SHALL, without APB_MASTER_TIMEOUT_EN, contain no counter and wait in ACCESS indefinitely.

Structure
REQ-022 SHALL place state enum (IDLE=0, SETUP=1, ACCESS=2) and response-code constants in shared package apb_pkg.
REQ-023 SHALL implement decode (index -> one-hot PSEL, out-of-range flag) in sub-module apb_sel_decode.

Verification
REQ-024 Write addr 0x1_24, data 0xDEADBEEF, strb 0xF, slave 1 PREADY=1 -> PSEL=0010, PENABLE 0 then 1, rsp_valid at N+2, rsp_err=0.
REQ-025 Read slave 3 addr 0x3_10, PREADY low 3 ACCESS cycles, PRDATA=0x12345678 -> PSEL/PADDR stable 5 cycles, rsp_rdata=0x12345678.
REQ-026 Two back-to-back reads slave 0 then 2, req_valid held -> ACCESS->SETUP directly, no IDLE cycle, two rsp_valid pulses.
REQ-027 NUM_SLV=3, index 3 -> PSEL=0 throughout, rsp_err=1 after one cycle; PSLVERR=1 on slave 2 -> rsp_err=1.
REQ-028 Timeout macro, TIMEOUT_CYC=16, PREADY stuck 0 -> IDLE after 16 ACCESS cycles, rsp_err=1; PRESET mid-ACCESS -> outputs zero immediately, no rsp_valid.
